stream_rr_scheduler: RTL and testbench

//  Shares the single processing-FIFO write port between two image-stream requesters (slv0, slv1).

---
 rtl/arb_pkg.sv | 21 ++
 rtl/arb_rr_pick.sv | 21 ++
 rtl/stream_rr_scheduler.sv | 183 ++++++++++++++++++
 tb/tb_stream_rr_scheduler.sv | 371 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// Shared types for the two-requester stream scheduler: FSM states, mode/source types,
// and the state a given source is granted into.
package arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } arb_state_t;

  typedef logic [1:0] arb_mode_t;
  typedef logic       arb_src_t;

  localparam arb_src_t SRC0 = 1'b0;
  localparam arb_src_t SRC1 = 1'b1;

  function automatic arb_state_t gnt_state(input arb_src_t src);
    return (src == SRC1) ? GNT1 : GNT0;
  endfunction

endpackage

// File: rtl/arb_rr_pick.sv
// Two-way round-robin picker: on a tie the requester that did not go last wins.
module arb_rr_pick
  import arb_pkg::*;
(
  input  logic     i_req0,
  input  logic     i_req1,
  input  arb_src_t i_last_src,
  output logic     o_gnt_valid,
  output arb_src_t o_gnt_src
);

  always_comb begin
    o_gnt_valid = i_req0 | i_req1;
    o_gnt_src   = SRC0;
    if (i_req0 && i_req1)
      o_gnt_src = ~i_last_src;
    else if (i_req1)
      o_gnt_src = SRC1;
  end

endmodule

// File: rtl/stream_rr_scheduler.sv
// Packet-locked round-robin scheduler sharing the processing-FIFO write port between slv0/slv1.
// Optional idle-grant watchdog enabled by defining ARB_WATCHDOG_EN.
//
// state | meaning
// IDLE  | no grant; picks the next requester from the mode inputs
// GNT0  | slv0 owns the FIFO write port until last, burst cap, mstr_cmplt or watchdog
// GNT1  | slv1 owns the FIFO write port, same release rules
module stream_rr_scheduler
  import arb_pkg::*;
#(
  parameter int DW        = 32,
  parameter int PV_W      = 8,
  parameter int BURST_MAX = 16
`ifdef ARB_WATCHDOG_EN
  ,
  parameter int WD_CYC    = 255
`endif
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [1:0]      slv0_mode,
  input  logic            slv0_valid,
  input  logic [DW-1:0]   slv0_data,
  input  logic [PV_W-1:0] slv0_proc_val,
  input  logic            slv0_last,
  output logic            slv0_ready,
  input  logic [1:0]      slv1_mode,
  input  logic            slv1_valid,
  input  logic [DW-1:0]   slv1_data,
  input  logic [PV_W-1:0] slv1_proc_val,
  input  logic            slv1_last,
  output logic            slv1_ready,
  input  logic            fifo_full,
  input  logic            mstr_cmplt,
  output logic            out_valid,
  output logic [DW-1:0]   out_data,
  output logic [PV_W-1:0] out_proc_val,
  output logic [1:0]      out_mode,
  output logic            out_src,
  output logic            out_last,
  output logic            busy,
  output logic            wd_timeout
);

  localparam int CW = $clog2(BURST_MAX + 1);
  localparam logic [CW-1:0] CAP = CW'(BURST_MAX - 1);

  arb_state_t    r_state, w_state_nxt;
  arb_src_t      r_last_src, w_last_src_nxt;
  logic [CW-1:0] r_beat_cnt, w_beat_cnt_nxt;

  logic            r_out_valid;
  logic [DW-1:0]   r_out_data;
  logic [PV_W-1:0] r_out_proc_val;
  arb_mode_t       r_out_mode;
  arb_src_t        r_out_src;
  logic            r_out_last;

  logic     w_gnt0, w_gnt1, w_xfer, w_cur_last, w_release, w_wd_fire;
  arb_src_t w_cur_src, w_pick_last, w_pick_src;
  logic     w_pick_valid;

  assign w_gnt0     = (r_state == GNT0);
  assign w_gnt1     = (r_state == GNT1);
  assign slv0_ready = w_gnt0 && !fifo_full && !mstr_cmplt;
  assign slv1_ready = w_gnt1 && !fifo_full && !mstr_cmplt;
  assign w_xfer     = (slv0_valid && slv0_ready) || (slv1_valid && slv1_ready);
  assign w_cur_src  = w_gnt1 ? SRC1 : SRC0;
  assign w_cur_last = w_gnt1 ? slv1_last : slv0_last;
  assign w_release  = (w_xfer && (w_cur_last || (r_beat_cnt == CAP))) || w_wd_fire;

  // At release the outgoing source counts as "last", so a pending peer wins directly.
  assign w_pick_last = w_release ? w_cur_src : r_last_src;

  arb_rr_pick u_pick (
    .i_req0      (|slv0_mode),
    .i_req1      (|slv1_mode),
    .i_last_src  (w_pick_last),
    .o_gnt_valid (w_pick_valid),
    .o_gnt_src   (w_pick_src)
  );

  always_comb begin
    w_state_nxt    = r_state;
    w_last_src_nxt = r_last_src;
    w_beat_cnt_nxt = r_beat_cnt;
    case (r_state)
      IDLE: begin
        if (!mstr_cmplt && w_pick_valid) begin
          w_state_nxt    = gnt_state(w_pick_src);
          w_beat_cnt_nxt = '0;
        end
      end
      GNT0, GNT1: begin
        if (mstr_cmplt) begin
          w_state_nxt    = IDLE;
          w_last_src_nxt = w_cur_src;
          w_beat_cnt_nxt = '0;
        end else if (w_release) begin
          w_state_nxt    = w_pick_valid ? gnt_state(w_pick_src) : IDLE;
          w_last_src_nxt = w_cur_src;
          w_beat_cnt_nxt = '0;
        end else if (w_xfer) begin
          w_beat_cnt_nxt = r_beat_cnt + CW'(1);
        end
      end
      default: begin
        w_state_nxt    = IDLE;
        w_beat_cnt_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_last_src <= SRC1;
      r_beat_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_last_src <= w_last_src_nxt;
      r_beat_cnt <= w_beat_cnt_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid    <= 1'b0;
      r_out_data     <= '0;
      r_out_proc_val <= '0;
      r_out_mode     <= '0;
      r_out_src      <= SRC0;
      r_out_last     <= 1'b0;
    end else begin
      r_out_valid <= w_xfer;
      if (w_xfer) begin
        r_out_data     <= w_gnt1 ? slv1_data : slv0_data;
        r_out_proc_val <= w_gnt1 ? slv1_proc_val : slv0_proc_val;
        r_out_mode     <= w_gnt1 ? slv1_mode : slv0_mode;
        r_out_src      <= w_cur_src;
        r_out_last     <= w_cur_last;
      end
    end
  end

`ifdef ARB_WATCHDOG_EN
  localparam int WW = $clog2(WD_CYC + 1);

  logic [WW-1:0] r_wd_cnt;
  logic          r_wd_timeout;
  logic          w_wd_idle;

  assign w_wd_idle = (r_state != IDLE) && !(w_gnt1 ? slv1_valid : slv0_valid) && !fifo_full;
  assign w_wd_fire = w_wd_idle && !mstr_cmplt && (r_wd_cnt == WW'(WD_CYC - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wd_cnt     <= '0;
      r_wd_timeout <= 1'b0;
    end else begin
      r_wd_timeout <= w_wd_fire;
      if (!w_wd_idle || w_wd_fire || mstr_cmplt)
        r_wd_cnt <= '0;
      else
        r_wd_cnt <= r_wd_cnt + WW'(1);
    end
  end

  assign wd_timeout = r_wd_timeout;
`else
  assign w_wd_fire  = 1'b0;
  assign wd_timeout = 1'b0;
`endif

  assign out_valid    = r_out_valid;
  assign out_data     = r_out_data;
  assign out_proc_val = r_out_proc_val;
  assign out_mode     = r_out_mode;
  assign out_src      = r_out_src;
  assign out_last     = r_out_last;
  assign busy         = (r_state != IDLE);

endmodule

// File: tb/tb_stream_rr_scheduler.sv
// Directed bench for stream_rr_scheduler; the watchdog scenario runs when ARB_WATCHDOG_EN is defined.
module tb_stream_rr_scheduler;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  slv0_mode, slv1_mode;
  logic        slv0_valid, slv1_valid;
  logic [31:0] slv0_data, slv1_data;
  logic [7:0]  slv0_proc_val, slv1_proc_val;
  logic        slv0_last, slv1_last, slv0_ready, slv1_ready;
  logic        fifo_full, mstr_cmplt;
  logic        out_valid, out_src, out_last, busy, wd_timeout;
  logic [31:0] out_data;
  logic [7:0]  out_proc_val;
  logic [1:0]  out_mode;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [31:0] q0[$], q1[$];
  logic        l0q[$], l1q[$];
  logic        acc0, acc1;
  logic [31:0] log_data[$];
  logic [7:0]  log_pv[$];
  logic [1:0]  log_mode[$];
  logic        log_src[$], log_last[$];
  int          log_cyc[$], acc0_cyc[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  stream_rr_scheduler #(
    .DW(32), .PV_W(8), .BURST_MAX(16)
`ifdef ARB_WATCHDOG_EN
    , .WD_CYC(8)
`endif
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .slv0_mode(slv0_mode), .slv0_valid(slv0_valid), .slv0_data(slv0_data),
    .slv0_proc_val(slv0_proc_val), .slv0_last(slv0_last), .slv0_ready(slv0_ready),
    .slv1_mode(slv1_mode), .slv1_valid(slv1_valid), .slv1_data(slv1_data),
    .slv1_proc_val(slv1_proc_val), .slv1_last(slv1_last), .slv1_ready(slv1_ready),
    .fifo_full(fifo_full), .mstr_cmplt(mstr_cmplt),
    .out_valid(out_valid), .out_data(out_data), .out_proc_val(out_proc_val),
    .out_mode(out_mode), .out_src(out_src), .out_last(out_last),
    .busy(busy), .wd_timeout(wd_timeout)
  );

  function automatic logic [31:0] beat(input logic s, input int p, input int b);
    return {4'hC, 3'b000, s, p[7:0], b[15:0]};
  endfunction

  // Source model: presents the head of each queue, pops it after an accepting edge.
  initial begin
    slv0_valid = 0; slv1_valid = 0; slv0_data = 0; slv1_data = 0;
    slv0_proc_val = 0; slv1_proc_val = 0; slv0_last = 0; slv1_last = 0;
    forever begin
      @(negedge clk); #3;
      acc0 = slv0_valid && slv0_ready;
      acc1 = slv1_valid && slv1_ready;
      @(posedge clk); #1;
      if (acc0 && q0.size() > 0) begin
        void'(q0.pop_front()); void'(l0q.pop_front()); acc0_cyc.push_back(cyc);
      end
      if (acc1 && q1.size() > 0) begin
        void'(q1.pop_front()); void'(l1q.pop_front());
      end
      slv0_valid = (q0.size() > 0);
      slv0_data = slv0_valid ? q0[0] : 32'h0;
      slv0_last = slv0_valid ? l0q[0] : 1'b0;
      slv0_proc_val = slv0_data[7:0] ^ 8'h5A;
      slv1_valid = (q1.size() > 0);
      slv1_data = slv1_valid ? q1[0] : 32'h0;
      slv1_last = slv1_valid ? l1q[0] : 1'b0;
      slv1_proc_val = slv1_data[7:0] ^ 8'hA5;
    end
  end

  initial begin
    forever begin
      @(negedge clk); #1;
      if (out_valid === 1'b1) begin
        log_data.push_back(out_data); log_pv.push_back(out_proc_val);
        log_mode.push_back(out_mode); log_src.push_back(out_src);
        log_last.push_back(out_last); log_cyc.push_back(cyc);
      end
    end
  end

  task automatic push_pkt(input logic s, input int p, input int n);
    for (int i = 0; i < n; i++) begin
      if (s) begin q1.push_back(beat(s, p, i)); l1q.push_back(i == n - 1); end
      else   begin q0.push_back(beat(s, p, i)); l0q.push_back(i == n - 1); end
    end
  endtask

  task automatic wait_log(input int n, input string name);
    int k = 0;
    while (log_data.size() < n && k < 100) begin @(negedge clk); #2; k++; end
    checks++;
    if (log_data.size() < n) begin
      errors++; $display("FAIL %s: got %0d beats, expected %0d", name, log_data.size(), n);
    end
  endtask

  task automatic wait_busy(input logic want, input string name);
    int k = 0;
    while (busy !== want && k < 100) begin @(negedge clk); #2; k++; end
    checks++;
    if (busy !== want) begin
      errors++; $display("FAIL %s: busy got %b expected %b", name, busy, want);
    end
  endtask

  task automatic do_reset;
    rst_n = 0; slv0_mode = 0; slv1_mode = 0; fifo_full = 0; mstr_cmplt = 0;
    q0.delete(); q1.delete(); l0q.delete(); l1q.delete();
    log_data.delete(); log_pv.delete(); log_mode.delete(); log_src.delete();
    log_last.delete(); log_cyc.delete(); acc0_cyc.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
  endtask

  task automatic test_reset;
    rst_n = 0; slv0_mode = 0; slv1_mode = 0; fifo_full = 0; mstr_cmplt = 0;
    @(negedge clk); #2;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid: got %b expected 0", out_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b expected 0", busy); end
    checks++; if (out_data !== 32'h0) begin errors++; $display("FAIL rst_out_data: got %h expected 0", out_data); end
    checks++; if ({slv0_ready, slv1_ready} !== 2'b00) begin errors++; $display("FAIL rst_ready: got %b expected 00", {slv0_ready, slv1_ready}); end
    checks++; if ({out_src, out_last, out_mode, wd_timeout} !== 5'b0) begin errors++; $display("FAIL rst_misc: got %b expected 00000", {out_src, out_last, out_mode, wd_timeout}); end
    do_reset();
  endtask

  task automatic test_single;
    push_pkt(0, 1, 3);
    @(posedge clk); #1 slv0_mode = 2'b11;
    wait_busy(1, "t1_grant");
    wait_log(1, "t1_first");
    slv0_mode = 2'b00;
    wait_log(3, "t1_beats");
    if (log_data.size() >= 3) begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (log_data[i] !== beat(0, 1, i) || log_src[i] !== 1'b0 || log_last[i] !== (i == 2) ||
            log_pv[i] !== (beat(0, 1, i) & 32'hFF ^ 32'h5A)) begin
          errors++; $display("FAIL t1_beat%0d: got %h src %b last %b pv %h expected %h src 0 last %b",
                             i, log_data[i], log_src[i], log_last[i], log_pv[i], beat(0, 1, i), i == 2);
        end
      end
      checks++;
      if (log_cyc[2] - log_cyc[0] !== 2) begin errors++; $display("FAIL t1_consecutive: got span %0d expected 2", log_cyc[2] - log_cyc[0]); end
      checks++;
      if (acc0_cyc.size() == 0 || log_cyc[0] !== acc0_cyc[0]) begin errors++; $display("FAIL t1_latency: out at %0d, accept edge count %0d", log_cyc[0], acc0_cyc.size() ? acc0_cyc[0] : -1); end
      checks++;
      if (log_mode[0] !== 2'b11) begin errors++; $display("FAIL t1_mode: got %b expected 11", log_mode[0]); end
    end
    repeat (3) @(negedge clk); #2;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL t1_idle: busy got %b expected 0", busy); end
  endtask

  task automatic test_two_packets;
    do_reset();
    push_pkt(0, 2, 4); push_pkt(1, 2, 4);
    @(posedge clk); #1 slv0_mode = 2'b01; slv1_mode = 2'b01;
    wait_busy(1, "t2_grant");
    slv0_mode = 2'b00;
    wait_log(5, "t2_switch");
    slv1_mode = 2'b00;
    wait_log(8, "t2_beats");
    if (log_data.size() >= 8) begin
      for (int i = 0; i < 8; i++) begin
        checks++;
        if (log_data[i] !== beat(i >= 4, 2, i % 4) || log_src[i] !== (i >= 4)) begin
          errors++; $display("FAIL t2_order%0d: got %h src %b expected %h", i, log_data[i], log_src[i], beat(i >= 4, 2, i % 4));
        end
      end
      checks++;
      if (log_cyc[7] - log_cyc[0] !== 7) begin errors++; $display("FAIL t2_no_gap: got span %0d expected 7", log_cyc[7] - log_cyc[0]); end
    end
    wait_busy(0, "t2_idle");
    push_pkt(0, 3, 1); push_pkt(1, 3, 1);
    @(posedge clk); #1 slv0_mode = 2'b01; slv1_mode = 2'b01;
    wait_busy(1, "t2_tie_grant");
    slv0_mode = 2'b00;
    wait_log(9, "t2_tie_first");
    slv1_mode = 2'b00;
    wait_log(10, "t2_tie_beats");
    if (log_data.size() >= 10) begin
      checks++;
      if (log_data[8] !== beat(0, 3, 0) || log_data[9] !== beat(1, 3, 0)) begin
        errors++; $display("FAIL t2_tie: got %h,%h expected %h,%h", log_data[8], log_data[9], beat(0, 3, 0), beat(1, 3, 0));
      end
    end
    wait_busy(0, "t2_tie_idle");
  endtask

  task automatic test_burst_cap;
    logic [31:0] exp;
    log_data.delete(); log_src.delete(); log_last.delete(); log_cyc.delete();
    log_pv.delete(); log_mode.delete();
    push_pkt(1, 4, 20); push_pkt(0, 4, 4);
    @(posedge clk); #1 slv1_mode = 2'b01;
    wait_busy(1, "t3_grant");
    slv0_mode = 2'b01;
    wait_log(17, "t3_cap");
    slv0_mode = 2'b00;
    wait_log(21, "t3_resume");
    slv1_mode = 2'b00;
    wait_log(24, "t3_beats");
    if (log_data.size() >= 24) begin
      for (int i = 0; i < 24; i++) begin
        if (i < 16) exp = beat(1, 4, i);
        else if (i < 20) exp = beat(0, 4, i - 16);
        else exp = beat(1, 4, i - 4);
        checks++;
        if (log_data[i] !== exp || log_last[i] !== (i == 19 || i == 23)) begin
          errors++; $display("FAIL t3_seq%0d: got %h last %b expected %h", i, log_data[i], log_last[i], exp);
        end
      end
    end
    wait_busy(0, "t3_idle");
  endtask

  task automatic test_fifo_full;
    int n1;
    logic [31:0] exp;
    log_data.delete(); log_src.delete(); log_last.delete(); log_cyc.delete();
    log_pv.delete(); log_mode.delete();
    push_pkt(0, 5, 18); push_pkt(1, 5, 1);
    @(posedge clk); #1 slv0_mode = 2'b01; slv1_mode = 2'b01;
    wait_log(3, "t4_start");
    n1 = 0;
    @(posedge clk); #1 fifo_full = 1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk); #2;
      checks++;
      if (slv0_ready !== 1'b0) begin errors++; $display("FAIL t4_ready%0d: got %b expected 0", k, slv0_ready); end
      if (k == 1) n1 = log_data.size();
      if (k > 0) begin
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL t4_valid%0d: got %b expected 0", k, out_valid); end
      end
      @(posedge clk); #1;
    end
    checks++;
    if (log_data.size() !== n1) begin errors++; $display("FAIL t4_frozen: got %0d beats expected %0d", log_data.size(), n1); end
    fifo_full = 0;
    wait_log(17, "t4_cap");
    slv0_mode = 2'b00; slv1_mode = 2'b00;
    wait_log(19, "t4_beats");
    if (log_data.size() >= 19) begin
      for (int i = 0; i < 19; i++) begin
        if (i < 16) exp = beat(0, 5, i);
        else if (i == 16) exp = beat(1, 5, 0);
        else exp = beat(0, 5, i - 1);
        checks++;
        if (log_data[i] !== exp) begin errors++; $display("FAIL t4_seq%0d: got %h expected %h", i, log_data[i], exp); end
      end
    end
    wait_busy(0, "t4_idle");
  endtask

  task automatic test_mstr_cmplt;
    log_data.delete(); log_src.delete(); log_last.delete(); log_cyc.delete();
    log_pv.delete(); log_mode.delete();
    push_pkt(0, 6, 4);
    @(posedge clk); #1 slv0_mode = 2'b01;
    wait_busy(1, "t5_grant");
    slv0_mode = 2'b00;
    wait_log(1, "t5_first");
    mstr_cmplt = 1;
    #1;
    checks++; if (slv0_ready !== 1'b0) begin errors++; $display("FAIL t5_ready: got %b expected 0", slv0_ready); end
    @(posedge clk); #1 mstr_cmplt = 0;
    @(negedge clk); #2;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL t5_idle: busy got %b expected 0", busy); end
    checks++; if (out_valid !== 1'b0 || log_data.size() !== 1) begin errors++; $display("FAIL t5_no_accept: valid %b beats %0d expected 0/1", out_valid, log_data.size()); end
    push_pkt(1, 6, 1);
    @(posedge clk); #1 slv0_mode = 2'b01; slv1_mode = 2'b01;
    wait_log(2, "t5_tie");
    slv0_mode = 2'b00; slv1_mode = 2'b00;
    wait_log(5, "t5_beats");
    if (log_data.size() >= 5) begin
      checks++;
      if (log_src[1] !== 1'b1) begin errors++; $display("FAIL t5_tie_src: got %b expected 1", log_src[1]); end
      for (int i = 2; i < 5; i++) begin
        checks++;
        if (log_data[i] !== beat(0, 6, i - 1) || log_last[i] !== (i == 4)) begin
          errors++; $display("FAIL t5_seq%0d: got %h expected %h", i, log_data[i], beat(0, 6, i - 1));
        end
      end
    end
    wait_busy(0, "t5_end");
  endtask

  task automatic test_watchdog;
    int g;
    int k;
    do_reset();
`ifdef ARB_WATCHDOG_EN
    push_pkt(1, 7, 1);
    @(posedge clk); #1 slv0_mode = 2'b01; slv1_mode = 2'b01;
    wait_busy(1, "t6_grant");
    g = cyc; k = 0;
    while (wd_timeout !== 1'b1 && k < 30) begin @(negedge clk); #2; k++; end
    checks++;
    if (wd_timeout !== 1'b1 || cyc - g !== 8) begin errors++; $display("FAIL t6_timeout: pulse %b after %0d cycles expected 1 after 8", wd_timeout, cyc - g); end
    checks++;
    if (slv1_ready !== 1'b1) begin errors++; $display("FAIL t6_gnt1: slv1_ready got %b expected 1", slv1_ready); end
    slv0_mode = 2'b00; slv1_mode = 2'b00;
    @(negedge clk); #2;
    checks++;
    if (wd_timeout !== 1'b0) begin errors++; $display("FAIL t6_pulse_width: got %b expected 0", wd_timeout); end
    wait_log(1, "t6_beat");
    if (log_data.size() >= 1) begin
      checks++;
      if (log_data[0] !== beat(1, 7, 0)) begin errors++; $display("FAIL t6_data: got %h expected %h", log_data[0], beat(1, 7, 0)); end
    end
`else
    @(posedge clk); #1 slv0_mode = 2'b01;
    wait_busy(1, "t6_grant");
    g = 0;
    for (k = 0; k < 30; k++) begin
      @(negedge clk); #2;
      if (wd_timeout !== 1'b0) g++;
    end
    checks++;
    if (g !== 0 || busy !== 1'b1 || slv0_ready !== 1'b1) begin
      errors++; $display("FAIL t6_hold: pulses %0d busy %b ready %b expected 0 1 1", g, busy, slv0_ready);
    end
    push_pkt(0, 7, 1);
    slv0_mode = 2'b00;
    wait_log(1, "t6_beat");
`endif
    wait_busy(0, "t6_idle");
  endtask

  task automatic test_reset_mid;
    log_data.delete(); log_src.delete(); log_last.delete(); log_cyc.delete();
    log_pv.delete(); log_mode.delete();
    push_pkt(1, 8, 6);
    @(posedge clk); #1 slv1_mode = 2'b10;
    wait_busy(1, "t7_grant");
    slv1_mode = 2'b00;
    wait_log(2, "t7_beats");
    rst_n = 0;
    #1;
    checks++;
    if ({busy, out_valid, slv1_ready} !== 3'b000 || out_data !== 32'h0) begin
      errors++; $display("FAIL t7_async: busy %b valid %b ready %b data %h expected all 0", busy, out_valid, slv1_ready, out_data);
    end
    do_reset();
  endtask

  initial begin
    test_reset();
    test_single();
    test_two_packets();
    test_burst_cap();
    test_fifo_full();
    test_mstr_cmplt();
    test_watchdog();
    test_reset_mid();
    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
